sd_level_detect: RTL and testbench

- Multi-channel magnitude/activity detector for 1-bit sigma-delta bitstreams.
- Per channel:
  - a saturating run-length counter measures how long the input has held the same value;
  - a leaky integrator accumulates the run length into a magnitude estimate;
  - a hysteresis state machine with hold qualification flags sustained activity.
- Sits after the sigma-delta front ends and feeds level metering and squelch/gating logic.
- Successor to the single-channel magnitude detector: adds channel count, parametrised run-word sizing, integrator saturation, thresholds and an output strobe.

---
 rtl/sd_pkg.sv | 28 ++
 rtl/sd_level_chan.sv | 108 ++++++++++
 rtl/sd_level_detect.sv | 64 ++++++
 tb/tb_sd_level_detect.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state encoding and saturating helpers for the level detector
package sd_pkg;

    typedef enum logic [1:0] {
        QUIET  = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2
    } sd_state_e;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned GAIN_DEF  = 6;
    localparam int unsigned ACC_W     = WIDTH_DEF + GAIN_DEF;

    // Generic saturating add: result clamps to 2^w-1 (w <= 64); callers size-cast the result.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (65'd1 << w) - 65'd1;
        return (sum > max_val) ? max_val[63:0] : sum[63:0];
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] a, input int unsigned w);
        return sat_add(a, 64'd1, w);
    endfunction

endpackage

// File: rtl/sd_level_chan.sv
// rtl/sd_level_chan.sv - one channel: run-length counter, leaky integrator, hysteresis FSM
module sd_level_chan
    import sd_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int GAIN        = 6,
    parameter int RUN_WIDTH   = 8,
    parameter int RUN_SHIFT   = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] thresh_hi,
    input  logic [WIDTH-1:0] thresh_lo,
    output logic [WIDTH-1:0] out,
    output logic             active,
    output logic             active_rise
);

    localparam int CH_ACC_W = WIDTH + GAIN;
    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);

    logic [CH_ACC_W-1:0]  acc_q, acc_d;
    logic [RUN_WIDTH-1:0] run_q, run_d;
    logic                 prev_q, prev_d;
    sd_state_e            state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 rise_q, rise_d;
    logic [HOLD_W-1:0]    hold_inc;

    assign out         = acc_q[CH_ACC_W-1:GAIN];
    assign active      = (state_q == ACTIVE);
    assign active_rise = rise_q;
    assign hold_inc    = hold_q + 1'b1;

    always_comb begin
        acc_d   = acc_q;
        run_d   = run_q;
        prev_d  = prev_q;
        state_d = state_q;
        hold_d  = hold_q;
        rise_d  = 1'b0;
        if (en) begin
            prev_d = in_bit;
            run_d  = (in_bit != prev_q) ? RUN_WIDTH'(1)
                                        : RUN_WIDTH'(sat_inc(64'(run_q), RUN_WIDTH));
            // Leak never underflows (acc>>GAIN <= acc); only the add needs clamping.
            acc_d  = CH_ACC_W'(sat_add(64'(acc_q - (acc_q >> GAIN)),
                                       64'(run_q) << RUN_SHIFT, CH_ACC_W));
            case (state_q)
                QUIET: begin
                    if (out >= thresh_hi) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d = ACTIVE;
                            hold_d  = '0;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ARMING;
                            hold_d  = HOLD_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (out < thresh_hi) begin
                        state_d = QUIET;
                        hold_d  = '0;
                    end else if (hold_inc == HOLD_W'(HOLD_CYCLES)) begin
                        state_d = ACTIVE;
                        hold_d  = '0;
                        rise_d  = 1'b1;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                ACTIVE: begin
                    if (out < thresh_lo) begin
                        state_d = QUIET;
                    end
                end
                default: begin
                    state_d = QUIET;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            run_q   <= RUN_WIDTH'(1);
            prev_q  <= 1'b0;
            state_q <= QUIET;
            hold_q  <= '0;
            rise_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            run_q   <= run_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            rise_q  <= rise_d;
        end
    end

endmodule

// File: rtl/sd_level_detect.sv
// rtl/sd_level_detect.sv - multi-channel sigma-delta magnitude/activity detector top
module sd_level_detect
    import sd_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 16,
    parameter int GAIN        = 6,
    parameter int RUN_WIDTH   = 8,
    parameter int RUN_SHIFT   = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       in,
    input  logic [WIDTH-1:0]          thresh_hi,
    input  logic [WIDTH-1:0]          thresh_lo,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS-1:0]       active_rise
);

    if (RUN_WIDTH + RUN_SHIFT > WIDTH + GAIN) begin : g_bad_run_sizing
        $error("sd_level_detect: RUN_WIDTH+RUN_SHIFT must not exceed WIDTH+GAIN");
    end

    logic out_valid_q, out_valid_d;

    always_comb begin
        out_valid_d = en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        sd_level_chan #(
            .WIDTH      (WIDTH),
            .GAIN       (GAIN),
            .RUN_WIDTH  (RUN_WIDTH),
            .RUN_SHIFT  (RUN_SHIFT),
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .in_bit     (in[c]),
            .thresh_hi  (thresh_hi),
            .thresh_lo  (thresh_lo),
            .out        (out[c*WIDTH +: WIDTH]),
            .active     (active[c]),
            .active_rise(active_rise[c])
        );
    end

endmodule

// File: tb/tb_sd_level_detect.sv
// tb/tb_sd_level_detect.sv - self-checking bench for sd_level_detect against a behavioural model
module tb_sd_level_detect;

    localparam int    CH      = 2;
    localparam int    W       = 16;
    localparam int    G       = 6;
    localparam int    RS      = 8;
    localparam int    HOLD    = 4;
    localparam int    RUN_MAX = 255;
    localparam longint ACC_MAX = (longint'(1) << (W + G)) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [CH-1:0]     in_b = '0;
    logic [W-1:0]      hi = 16'hffff;
    logic [W-1:0]      lo = 16'h0000;
    logic [CH*W-1:0]   out_w;
    logic              out_valid;
    logic [CH-1:0]     active;
    logic [CH-1:0]     active_rise;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: 0 = quiet, 1 = arming, 2 = active
    longint m_acc[CH];
    int     m_run[CH];
    bit     m_prev[CH];
    int     m_state[CH];
    int     m_hold[CH];
    bit     m_rise[CH];
    bit     m_valid;

    sd_level_detect #(
        .CHANNELS(CH), .WIDTH(W), .GAIN(G), .RUN_WIDTH(8), .RUN_SHIFT(RS), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in(in_b), .thresh_hi(hi), .thresh_lo(lo),
        .out(out_w), .out_valid(out_valid), .active(active), .active_rise(active_rise)
    );

    always #5 clk = ~clk;

    function automatic longint mout(input int c);
        return m_acc[c] >> G;
    endfunction

    function automatic longint dout(input int c);
        return longint'(out_w[c*W +: W]);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("out[%0d]", c), dout(c), mout(c));
            chk($sformatf("active[%0d]", c), longint'(active[c]), longint'(m_state[c] == 2));
            chk($sformatf("active_rise[%0d]", c), longint'(active_rise[c]), longint'(m_rise[c]));
        end
        chk("out_valid", longint'(out_valid), longint'(m_valid));
    endtask

    task automatic step(input bit e, input logic [CH-1:0] i, input bit r);
        en   = e;
        in_b = i;
        rst  = r;
        if (r) begin
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0; m_run[c] = 1; m_prev[c] = 0;
                m_state[c] = 0; m_hold[c] = 0; m_rise[c] = 0;
            end
            m_valid = 0;
        end else begin
            m_valid = e;
            for (int c = 0; c < CH; c++) begin
                longint o;
                longint nxt;
                m_rise[c] = 0;
                if (e) begin
                    o = mout(c);
                    if (m_state[c] == 0) begin
                        if (o >= longint'(hi)) begin
                            if (HOLD == 1) begin m_state[c] = 2; m_rise[c] = 1; end
                            else begin m_state[c] = 1; m_hold[c] = 1; end
                        end
                    end else if (m_state[c] == 1) begin
                        if (o < longint'(hi)) begin
                            m_state[c] = 0; m_hold[c] = 0;
                        end else begin
                            m_hold[c]++;
                            if (m_hold[c] == HOLD) begin m_state[c] = 2; m_rise[c] = 1; m_hold[c] = 0; end
                        end
                    end else begin
                        if (o < longint'(lo)) m_state[c] = 0;
                    end
                    nxt = m_acc[c] - (m_acc[c] >> G) + (longint'(m_run[c]) << RS);
                    if (nxt > ACC_MAX) nxt = ACC_MAX;
                    if (i[c] != m_prev[c]) m_run[c] = 1;
                    else if (m_run[c] < RUN_MAX) m_run[c]++;
                    m_prev[c] = i[c];
                    m_acc[c]  = nxt;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        longint prev_out;
        int     rise_cnt;
        int     first_edge;
        int     act_edge;
        int     edges;
        int     ens;
        int     valid_cnt;
        logic [CH-1:0] cur;
        bit     e;

        // Reset with en held high
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b11, 1'b1);
        chk("reset_out0", dout(0), 0);
        chk("reset_valid", longint'(out_valid), 0);

        // Constant input: monotonic rise to the saturated fixed point
        prev_out = 0;
        for (int k = 0; k < 2000; k++) begin
            step(1'b1, 2'b00, 1'b0);
            chk("monotonic", longint'(dout(0) >= prev_out), 1);
            prev_out = dout(0);
        end
        chk("converge_const0", dout(0), 65280);
        chk("converge_const1", dout(1), 65280);

        // Alternating ch0, constant ch1
        for (int k = 0; k < 1500; k++) begin
            step(1'b1, {1'b0, (k % 2 == 0)}, 1'b0);
        end
        chk("converge_alt0", dout(0), 256);
        chk("converge_alt1", dout(1), 65280);

        // Abandoned arming
        step(1'b1, 2'b00, 1'b1);
        hi = 16'hffff;
        for (int k = 0; k < 200 && mout(0) < 2000; k++) step(1'b1, 2'b00, 1'b0);
        hi = W'(mout(0));
        rise_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 2'b00, 1'b0);
            rise_cnt += int'(active_rise[0]);
        end
        hi = 16'hffff;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 2'b00, 1'b0);
            rise_cnt += int'(active_rise[0]);
        end
        chk("abandon_rise", rise_cnt, 0);
        chk("abandon_active", longint'(active[0]), 0);

        // Reset in the middle of arming, then a full hold is needed again
        hi = W'(mout(0));
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b1);
        chk("midrst_out0", dout(0), 0);
        chk("midrst_active", longint'(active), 0);
        hi = 16'd1000;
        lo = 16'd500;
        first_edge = -1; act_edge = -1; edges = 0; rise_cnt = 0;
        for (int k = 0; k < 400 && (act_edge < 0 || edges < act_edge + 10); k++) begin
            step(1'b1, 2'b00, 1'b0);
            edges++;
            rise_cnt += int'(active_rise[0]);
            if (first_edge < 0 && dout(0) >= 1000) first_edge = edges;
            if (act_edge < 0 && active[0] === 1'b1) act_edge = edges;
        end
        chk("activated", longint'(act_edge >= 0), 1);
        chk("hold_delay", act_edge - first_edge, HOLD);
        chk("rise_pulses", rise_cnt, 1);

        // Release once the magnitude falls below thresh_lo
        for (int k = 0; k < 2000 && active[0] === 1'b1; k++) begin
            step(1'b1, {1'b0, (k % 2 == 0)}, 1'b0);
        end
        chk("released", longint'(active[0]), 0);
        chk("release_level", longint'(dout(0) < 600), 1);

        // en gating: one enabled cycle in four
        step(1'b1, 2'b00, 1'b1);
        hi = 16'd300;
        lo = 16'd200;
        ens = 0; valid_cnt = 0; cur = '0;
        for (int k = 0; k < 800; k++) begin
            e = (k % 4 == 0);
            for (int c = 0; c < CH; c++) if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
            step(e, cur, 1'b0);
            ens += int'(e);
            valid_cnt += int'(out_valid);
        end
        chk("valid_count", valid_cnt, ens);

        // Randomised mix of enables, thresholds, inputs and occasional reset
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) begin
                hi = W'($urandom_range(0, 4000));
                lo = W'($urandom_range(0, 4000));
            end
            for (int c = 0; c < CH; c++) if ($urandom_range(0, 15) == 0) cur[c] = ~cur[c];
            step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
